// File: rtl/lcd_serial_pkg.sv
// LCD serial link shared definitions.
// Frame layout, R/W encodings and responder states.
package lcd_serial_pkg;

  localparam int RW_BIT     = 0;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 16;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_WAIT_CS
  } state_t;

endpackage

// File: rtl/lcd_serial_responder_if.sv
// LCD serial link pins.
// Master drives clock/enable/data, responder drives return line.
interface lcd_serial_responder_if;
  logic i_sclk;
  logic i_csN;
  logic i_sdi;
  logic o_sdo;
  logic o_sdoEnable;

  modport master (
    output i_sclk, i_csN, i_sdi,
    input  o_sdo, o_sdoEnable
  );

  modport slave (
    input  i_sclk, i_csN, i_sdi,
    output o_sdo, o_sdoEnable
  );
endinterface

// File: rtl/lcd_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulses.
// Pulses come from the last two synchronised samples.
module lcd_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the pin through the chain, keep one older sample.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/lcd_serial_responder.sv
// LCD serial link responder with register bank.
// Decodes write/read frames, returns read data MSB-first.
module lcd_serial_responder
  import lcd_serial_pkg::*;
#(
  parameter int         REG_COUNT   = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  lcd_serial_responder_if.slave lnk,
  output logic          o_busy,
  output logic          o_wrStrobe,
  output logic [6:0]    o_wrAddress,
  output logic [7:0]    o_wrData,
  output logic          o_rdStrobe,
  output logic          o_frameError
);

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_BITS);
  localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;

  lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk  (i_clock),
    .rst_n(i_reset_n),
    .d    (lnk.i_sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk  (i_clock),
    .rst_n(i_reset_n),
    .d    (lnk.i_csN),
    .q    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sdi_s;

  // Data line needs only the synchroniser.
  always_comb begin
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], lnk.i_sdi};
  end

  // Data line synchroniser register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) sdi_sync_q <= '0;
    else            sdi_sync_q <= sdi_sync_d;
  end

  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] shift_q, shift_d;
  logic       busy_q, busy_d;
  logic       sdo_q, sdo_d;
  logic       sdo_en_q, sdo_en_d;
  logic       wr_stb_q, wr_stb_d;
  logic       rd_stb_q, rd_stb_d;
  logic       err_q, err_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] bank_q [REG_COUNT];
  logic [7:0] bank_d [REG_COUNT];

  logic [6:0] addr_nxt;
  logic [7:0] data_nxt;
  logic [7:0] rd_val;
  logic       in_frame;
  logic       abort;
  logic       addr_done;
  logic       frame_done;
  logic       wr_impl;

  // Shared decode terms and the read-back mux.
  always_comb begin
    addr_nxt   = {addr_q[5:0], sdi_s};
    data_nxt   = {shift_q[6:0], sdi_s};
    in_frame   = (state_q == ST_CMD) ||
                 (state_q == ST_ADDR) ||
                 (state_q == ST_WR_DATA) ||
                 (state_q == ST_RD_DATA);
    abort      = cs_rise && in_frame;
    addr_done  = sclk_rise && (bit_cnt_q == ADDR_LAST);
    frame_done = sclk_rise && (bit_cnt_q == FRAME_LAST);
    wr_impl    = int'(addr_q) < REG_COUNT;
    rd_val     = 8'h00;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (addr_nxt == 7'(i)) rd_val = bank_q[i];
    end
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; an early csN rise aborts any frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (cs_fall && !sclk_s) state_d = ST_CMD;
      ST_CMD:
        if (sclk_rise) state_d = ST_ADDR;
      ST_ADDR:
        if (addr_done)
          state_d = (rw_q == RW_READ) ? ST_RD_DATA : ST_WR_DATA;
      ST_WR_DATA:
        if (frame_done) state_d = ST_WAIT_CS;
      ST_RD_DATA:
        if (frame_done) state_d = ST_WAIT_CS;
      ST_WAIT_CS:
        if (cs_s) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Datapath and output pulses per state.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    sdo_d     = sdo_q;
    sdo_en_d  = sdo_en_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bank_d    = bank_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall && !sclk_s) begin
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          rw_d      = sdi_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_ADDR: begin
        if (sclk_rise) begin
          addr_d    = addr_nxt;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (addr_done && rw_q == RW_READ) begin
          rd_stb_d = 1'b1;
          shift_d  = rd_val;
        end
      end
      ST_WR_DATA: begin
        if (sclk_rise) begin
          shift_d   = data_nxt;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (frame_done) begin
          if (wr_impl) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_nxt;
            for (int i = 0; i < REG_COUNT; i++) begin
              if (addr_q == 7'(i)) bank_d[i] = data_nxt;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RD_DATA: begin
        if (sclk_fall) begin
          sdo_d    = shift_q[7];
          shift_d  = {shift_q[6:0], 1'b0};
          sdo_en_d = 1'b1;
        end
        if (sclk_rise) bit_cnt_d = bit_cnt_q + 4'd1;
        if (frame_done) begin
          sdo_d    = 1'b0;
          sdo_en_d = 1'b0;
        end
      end
      ST_WAIT_CS: begin
        sdo_d    = 1'b0;
        sdo_en_d = 1'b0;
        if (cs_s) busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
    if (abort) begin
      busy_d    = 1'b0;
      sdo_d     = 1'b0;
      sdo_en_d  = 1'b0;
      err_d     = 1'b1;
      wr_stb_d  = 1'b0;
      rd_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      bank_d    = bank_q;
    end
  end

  // Datapath, output and register bank flops.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      sdo_q     <= 1'b0;
      sdo_en_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) bank_q[i] <= RESET_VALUE;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      sdo_q     <= sdo_d;
      sdo_en_q  <= sdo_en_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      for (int i = 0; i < REG_COUNT; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign lnk.o_sdo       = sdo_q;
  assign lnk.o_sdoEnable = sdo_en_q;
  assign o_busy          = busy_q;
  assign o_wrStrobe      = wr_stb_q;
  assign o_wrAddress     = wr_addr_q;
  assign o_wrData        = wr_data_q;
  assign o_rdStrobe      = rd_stb_q;
  assign o_frameError    = err_q;

endmodule
